// File: rtl/configuration_pkg.sv
// rtl/configuration_pkg.sv - shared block geometry, result start block and writer state encoding
package configuration;
  localparam int          BLOCK_BYTES_DEFAULT = 512;
  localparam logic [31:0] RESULT_START_BLOCK  = 32'h0000_0100;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_REQ, FETCH, SEND, DRAIN, CHECK, ERR
  } wr_state_t;
endpackage

// File: rtl/result_block_writer_ram.sv
// rtl/result_block_writer_ram.sv - simple dual-port byte RAM holding both result banks
module dp_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/result_block_writer.sv
// rtl/result_block_writer.sv - ping-pong capture of result bytes and block writes to the SD host
module result_block_writer
  import configuration::*;
#(
  parameter logic [31:0] START_BLOCK = RESULT_START_BLOCK,
  parameter int          BLOCK_BYTES = BLOCK_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic [7:0]  in_data_1,
  input  logic        in_valid_1,
  input  logic [7:0]  in_data_2,
  input  logic        in_valid_2,
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic        spi_crc_err,
  output logic [31:0] spi_block_addr,
  output logic [7:0]  spi_data_in,
  output logic        spi_w_block,
  output logic        spi_w_byte,
  output logic [31:0] blocks_written,
  output logic        overflow,
  output logic        error,
  output logic        idle
);
  localparam int IW = $clog2(BLOCK_BYTES);
  typedef logic [IW:0] fill_t;

  wr_state_t   state;
  logic [1:0]  ready;
  fill_t       fill [2];
  logic        cur_bank, wr_bank;
  logic        hold_valid;
  logic [7:0]  hold_data;
  logic        ram_we;
  logic [IW:0] ram_waddr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [IW-1:0] idx;
  logic        pad;

  logic        src_valid, hold_load, hold_drain, drop2;
  logic [7:0]  src_data;
  logic        accept, bank_full, do_flush;
  fill_t       next_fill;

  // ch1 always wins the write slot; a pending ch2 byte waits in the hold register
  always_comb begin
    src_valid  = 1'b0;
    src_data   = 8'h00;
    hold_load  = 1'b0;
    drop2      = 1'b0;
    if (enable && in_valid_1) begin
      src_valid = 1'b1;
      src_data  = in_data_1;
    end else if (hold_valid) begin
      src_valid = 1'b1;
      src_data  = hold_data;
    end else if (enable && in_valid_2) begin
      src_valid = 1'b1;
      src_data  = in_data_2;
    end
    hold_drain = hold_valid && !(enable && in_valid_1);
    if (enable && in_valid_2 && (in_valid_1 || hold_valid)) begin
      if (hold_valid) drop2 = 1'b1;
      else            hold_load = 1'b1;
    end
  end

  assign accept    = src_valid && !ready[cur_bank];
  assign next_fill = fill[cur_bank] + fill_t'(accept);
  assign bank_full = accept && (next_fill == fill_t'(BLOCK_BYTES));
  assign do_flush  = flush && !ready[cur_bank] && !bank_full && (next_fill != '0);
  assign idle      = (state == IDLE) && (ready == 2'b00);

  dp_byte_ram #(.DEPTH(2 * BLOCK_BYTES), .AW(IW + 1)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({wr_bank, idx}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ready          <= 2'b00;
      fill[0]        <= '0;
      fill[1]        <= '0;
      cur_bank       <= 1'b0;
      wr_bank        <= 1'b0;
      hold_valid     <= 1'b0;
      hold_data      <= 8'h00;
      ram_we         <= 1'b0;
      ram_waddr      <= '0;
      ram_wdata      <= 8'h00;
      idx            <= '0;
      pad            <= 1'b0;
      spi_block_addr <= '0;
      spi_data_in    <= 8'h00;
      spi_w_block    <= 1'b0;
      spi_w_byte     <= 1'b0;
      blocks_written <= '0;
      overflow       <= 1'b0;
      error          <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data_2;
      end else if (hold_drain) begin
        hold_valid <= 1'b0;
      end
      if ((src_valid && !accept) || drop2) overflow <= 1'b1;

      ram_we    <= accept;
      ram_waddr <= {cur_bank, fill[cur_bank][IW-1:0]};
      ram_wdata <= src_data;
      if (accept) fill[cur_bank] <= next_fill;
      if (bank_full || do_flush) begin
        ready[cur_bank] <= 1'b1;
        cur_bank        <= ~cur_bank;
      end

      // the writer only ever touches wr_bank, which is ready and so never the capture target
      case (state)
        IDLE: if (ready[wr_bank]) begin
          spi_w_block    <= 1'b1;
          spi_block_addr <= START_BLOCK + blocks_written;
          state          <= START;
        end
        START: if (spi_busy) begin
          spi_w_block <= 1'b0;
          idx         <= '0;
          state       <= WAIT_REQ;
        end
        WAIT_REQ: if (!spi_busy) begin
          pad   <= ({1'b0, idx} >= fill[wr_bank]);
          state <= FETCH;
        end
        FETCH: begin
          spi_data_in <= pad ? 8'h00 : ram_rdata;
          spi_w_byte  <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          spi_w_byte <= 1'b0;
          if (spi_busy) begin
            if (idx == {IW{1'b1}}) state <= DRAIN;
            else begin
              idx   <= idx + 1'b1;
              state <= WAIT_REQ;
            end
          end
        end
        DRAIN: if (!spi_busy) state <= CHECK;
        CHECK: begin
          if (spi_err || spi_crc_err) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            blocks_written <= blocks_written + 32'd1;
            ready[wr_bank] <= 1'b0;
            fill[wr_bank]  <= '0;
            wr_bank        <= ~wr_bank;
            state          <= IDLE;
          end
        end
        ERR: state <= ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_result_block_writer.sv
// tb/tb_result_block_writer.sv - scoreboard bench for result_block_writer with an sdspihost model
module tb_result_block_writer;
  import configuration::*;
  localparam int BB = 512;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, flush = 1'b0;
  logic [7:0]  in_data_1 = 8'h00, in_data_2 = 8'h00;
  logic        in_valid_1 = 1'b0, in_valid_2 = 1'b0;
  logic        spi_busy = 1'b0, spi_err = 1'b0, spi_crc_err = 1'b0;
  logic [31:0] spi_block_addr, blocks_written;
  logic [7:0]  spi_data_in;
  logic        spi_w_block, spi_w_byte, overflow, error, idle;

  int checks = 0, errors = 0;
  logic [7:0]  exp_q[$], got_q[$];
  logic [31:0] exp_addr_q[$], got_addr_q[$];
  int busy_len = 4;
  bit crc_inject = 1'b0;
  int m_cnt = 0, m_nbytes = 0, m_done = 0;
  bit m_in_block = 1'b0, m_last = 1'b0;

  always #5 clk = ~clk;

  result_block_writer dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_data_1(in_data_1), .in_valid_1(in_valid_1),
    .in_data_2(in_data_2), .in_valid_2(in_valid_2),
    .spi_busy(spi_busy), .spi_err(spi_err), .spi_crc_err(spi_crc_err),
    .spi_block_addr(spi_block_addr), .spi_data_in(spi_data_in),
    .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte),
    .blocks_written(blocks_written), .overflow(overflow),
    .error(error), .idle(idle)
  );

  // sdspihost model: busy after each request, crc status raised when a block finishes
  always @(negedge clk) begin
    if (rst) begin
      spi_busy = 1'b0; spi_crc_err = 1'b0; spi_err = 1'b0;
      m_cnt = 0; m_nbytes = 0; m_done = 0; m_in_block = 1'b0; m_last = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        spi_busy = 1'b0;
        if (m_last) begin
          m_last = 1'b0; m_in_block = 1'b0;
          spi_crc_err = crc_inject;
          m_done++;
        end
      end
    end else if (!m_in_block && spi_w_block) begin
      m_in_block = 1'b1; m_nbytes = 0; spi_crc_err = 1'b0;
      got_addr_q.push_back(spi_block_addr);
      spi_busy = 1'b1; m_cnt = 3;
    end else if (m_in_block && spi_w_byte) begin
      got_q.push_back(spi_data_in);
      m_nbytes++;
      m_last = (m_nbytes == BB);
      spi_busy = 1'b1; m_cnt = busy_len;
    end
  end

  function automatic int blk_diff(output int first);
    int n;
    logic [7:0] g, e;
    n = 0; first = -1;
    if (got_q.size() < BB || exp_q.size() < BB) return BB;
    for (int i = 0; i < BB; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e) begin n++; if (first < 0) first = i; end
    end
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    crc_inject = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete(); got_q.delete(); exp_addr_q.delete(); got_addr_q.delete();
    #1 rst = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send1(input logic [7:0] d, input bit f);
    in_data_1 = d; in_valid_1 = 1'b1; flush = f;
    @(posedge clk); #1;
    in_valid_1 = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int c = 0;
    while (m_done < n && c < budget) begin @(posedge clk); #1; c++; end
    repeat (4) @(posedge clk);
    #1 ok = (m_done >= n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    checks++; if ({spi_w_block, spi_w_byte} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {spi_w_block, spi_w_byte}); end
    checks++; if ({blocks_written, spi_block_addr, spi_data_in} !== 72'h0) begin errors++; $display("FAIL reset_values got %h exp 0", {blocks_written, spi_block_addr, spi_data_in}); end
    checks++; if ({overflow, error} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, error}); end
  endtask

  task automatic test_full_block();
    bit ok; int first, d;
    do_reset(); busy_len = 4;
    exp_addr_q.push_back(32'h100);
    for (int i = 0; i < BB; i++) begin exp_q.push_back(8'(i)); send1(8'(i), 1'b0); end
    wait_done(1, 20000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout got %0d exp 1 blocks", m_done); end
    checks++; if (got_addr_q[0] !== exp_addr_q[0]) begin errors++; $display("FAIL full_addr got %h exp %h", got_addr_q[0], exp_addr_q[0]); end
    d = blk_diff(first);
    checks++; if (d !== 0) begin errors++; $display("FAIL full_data got %0d bad bytes (first %0d) exp 0", d, first); end
    checks++; if (blocks_written !== 32'd1) begin errors++; $display("FAIL full_count got %0d exp 1", blocks_written); end
    checks++; if ({overflow, idle} !== 2'b01) begin errors++; $display("FAIL full_flags got %b exp 01", {overflow, idle}); end
  endtask

  task automatic test_flush();
    bit ok; int first, d, wb;
    do_reset(); busy_len = 4;
    exp_addr_q.push_back(32'h100);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    for (int i = 3; i < BB; i++) exp_q.push_back(8'h00);
    send1(8'hA1, 1'b0); send1(8'hA2, 1'b0); send1(8'hA3, 1'b1);
    wait_done(1, 20000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_timeout got %0d exp 1 blocks", m_done); end
    checks++; if (got_addr_q[0] !== 32'h100) begin errors++; $display("FAIL flush_addr got %h exp 00000100", got_addr_q[0]); end
    d = blk_diff(first);
    checks++; if (d !== 0) begin errors++; $display("FAIL flush_data got %0d bad bytes (first %0d) exp 0", d, first); end
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    wb = 0;
    repeat (50) begin @(posedge clk); #1 if (spi_w_block) wb++; end
    checks++; if (wb !== 0) begin errors++; $display("FAIL flush_empty got %0d w_block cycles exp 0", wb); end
  endtask

  task automatic test_dual();
    bit ok; int first, d;
    do_reset(); busy_len = 4;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      in_data_1 = 8'h11; in_data_2 = 8'h22; in_valid_1 = 1'b1; in_valid_2 = 1'b1;
      @(posedge clk); #1 in_valid_1 = 1'b0; in_valid_2 = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 6; i < BB; i++) exp_q.push_back(8'h00);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    wait_done(1, 20000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dual_timeout got %0d exp 1 blocks", m_done); end
    d = blk_diff(first);
    checks++; if (d !== 0) begin errors++; $display("FAIL dual_order got %0d bad bytes (first %0d) exp 0", d, first); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dual_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_back_to_back();
    bit ok; int first, d;
    do_reset(); busy_len = 20;
    for (int i = 0; i < 1600; i++) begin
      if (i < 2 * BB) exp_q.push_back(8'(i ^ (i >> 8)));
      in_data_1 = 8'(i ^ (i >> 8)); in_valid_1 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid_1 = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow got %b exp 1", overflow); end
    wait_done(2, 40000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got %0d exp 2 blocks", m_done); end
    checks++; if (got_addr_q.size() < 2 || got_addr_q[0] !== 32'h100 || got_addr_q[1] !== 32'h101) begin
      errors++; $display("FAIL b2b_addr got %0d blocks exp 00000100,00000101", got_addr_q.size());
    end
    for (int b = 0; b < 2; b++) begin
      d = blk_diff(first);
      checks++; if (d !== 0) begin errors++; $display("FAIL b2b_data%0d got %0d bad bytes (first %0d) exp 0", b, d, first); end
    end
    checks++; if (blocks_written !== 32'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", blocks_written); end
  endtask

  task automatic test_crc_err();
    bit ok; int wb;
    do_reset(); busy_len = 4; crc_inject = 1'b1;
    for (int i = 0; i < BB; i++) send1(8'(i), 1'b0);
    wait_done(1, 20000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL crc_timeout got %0d exp 1 blocks", m_done); end
    checks++; if ({error, dut.state} !== {1'b1, ERR}) begin errors++; $display("FAIL crc_state got %b/%0d exp 1/%0d", error, dut.state, ERR); end
    checks++; if (blocks_written !== 32'd0) begin errors++; $display("FAIL crc_count got %0d exp 0", blocks_written); end
    wb = 0;
    for (int i = 0; i < BB + 1; i++) begin
      in_data_1 = 8'(i); in_valid_1 = 1'b1;
      @(posedge clk); #1 if (spi_w_block) wb++;
    end
    in_valid_1 = 1'b0;
    repeat (50) begin @(posedge clk); #1 if (spi_w_block) wb++; end
    checks++; if (wb !== 0) begin errors++; $display("FAIL crc_no_wblock got %0d cycles exp 0", wb); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL crc_overflow got %b exp 1", overflow); end
  endtask

  task automatic test_reset_mid();
    bit ok, found; int c, first, d;
    do_reset(); busy_len = 4;
    for (int i = 0; i < BB; i++) send1(8'(i), 1'b0);
    found = 1'b0; c = 0;
    while (!found && c < 10000) begin
      @(posedge clk); #1 c++;
      if (spi_w_byte && m_nbytes == 100) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach got %0d bytes exp 100", m_nbytes); end
    rst = 1'b1; #1;
    checks++; if ({spi_w_byte, spi_w_block} !== 2'b00) begin errors++; $display("FAIL mid_async got %b exp 00", {spi_w_byte, spi_w_block}); end
    do_reset(); busy_len = 4;
    exp_addr_q.push_back(32'h100);
    for (int i = 0; i < BB; i++) begin exp_q.push_back(8'(i + 3)); send1(8'(i + 3), 1'b0); end
    wait_done(1, 20000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_timeout got %0d exp 1 blocks", m_done); end
    checks++; if (got_addr_q[0] !== 32'h100) begin errors++; $display("FAIL mid_addr got %h exp 00000100", got_addr_q[0]); end
    d = blk_diff(first);
    checks++; if (d !== 0) begin errors++; $display("FAIL mid_data got %0d bad bytes (first %0d) exp 0", d, first); end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_flush();
    test_dual();
    test_back_to_back();
    test_crc_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
